// File: rtl/floatingpointpkg.sv
`default_nettype none
// ============================================================================
//  Module      : floatingpointpkg
//  Description : Shared single-precision float type, zero constant and the
//                request-side FSM state encoding for fp_add_requester.
//  Revision    : 1.0 - initial release
// ============================================================================
package floatingpointpkg;

    // IEEE-754 single precision, MSB first
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float;

    localparam float FP_ZERO = float'(32'd0);

    // Request FSM: idle, pulse Go, wait for stale Ready to drop, wait for Ready
    typedef enum logic [1:0] {
        REQ_IDLE  = 2'd0,
        REQ_ISSUE = 2'd1,
        REQ_ACK   = 2'd2,
        REQ_WAIT  = 2'd3
    } req_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_op_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fp_op_fifo
//  Description : Synchronous FIFO holding operand pairs {A, B}. Power-of-two
//                depth; pointers wrap naturally. Push when full and pop when
//                empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_op_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_add_requester.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_requester
//  Description : Drives a FloatingPointAdder through its Go/Ready handshake.
//                Operand pairs are queued, issued one at a time with stable
//                operands, and results (or watchdog timeouts) are presented
//                on a valid/ready output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_requester
    import floatingpointpkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   InValid,
    output logic                   InReady,
    input  float                   InA,
    input  float                   InB,
    output logic                   OutValid,
    input  logic                   OutReady,
    output float                   OutResult,
    output logic                   OutZero,
    output logic                   OutInf,
    output logic                   OutNan,
    output logic                   OutTimeout,
    output logic                   AddGo,
    output float                   AddA,
    output float                   AddB,
    input  logic                   AddReady,
    input  float                   AddResult,
    input  logic                   AddZero,
    input  logic                   AddInf,
    input  logic                   AddNan,
    output logic                   Busy,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int            TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

    req_state_t    state;
    req_state_t    state_next;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [63:0]   fifo_head;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_inc;
    logic          timer_expired;
    logic          slot_free;
    logic          do_capture;
    logic          do_timeout;

    fp_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (ResetN),
        .push    (InValid),
        .pop     (fifo_pop),
        .wr_data ({InA, InB}),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (Count)
    );

    assign InReady       = !fifo_full;
    assign AddGo         = (state == REQ_ISSUE);
    assign Busy          = (state != REQ_IDLE);
    assign slot_free     = !OutValid || OutReady;
    // Saturating increment; expiry means this step lands on TIMEOUT
    assign timer_inc     = (timer == TIMER_MAX) ? timer : timer + TW'(1);
    assign timer_expired = (timer_inc == TIMER_MAX);

    // Next-state and handshake decisions
    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        unique case (state)
            REQ_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    state_next = REQ_ISSUE;
                end
            end
            REQ_ISSUE: begin
                state_next = REQ_ACK;
            end
            REQ_ACK: begin
                // A high Ready here is left over from the previous operation
                if (!AddReady) begin
                    state_next = REQ_WAIT;
                end else if (timer_expired && slot_free) begin
                    do_timeout = 1'b1;
                    state_next = REQ_IDLE;
                end
            end
            REQ_WAIT: begin
                if (AddReady) begin
                    // The adder holds Result/Ready until the next Go, so a
                    // blocked output slot simply stalls here
                    if (slot_free) begin
                        do_capture = 1'b1;
                        state_next = REQ_IDLE;
                    end
                end else if (timer_expired && slot_free) begin
                    do_timeout = 1'b1;
                    state_next = REQ_IDLE;
                end
            end
            default: state_next = REQ_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= REQ_IDLE;
        else         state <= state_next;
    end

    // Watchdog timer: cleared on issue and on entry to WAIT, counts while waiting
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            timer <= '0;
        end else if (fifo_pop) begin
            timer <= '0;
        end else if (state == REQ_ACK) begin
            timer <= AddReady ? timer_inc : '0;
        end else if (state == REQ_WAIT && !AddReady) begin
            timer <= timer_inc;
        end
    end

    // Operand registers change only on a pop, so they stay stable through the operation
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            AddA <= FP_ZERO;
            AddB <= FP_ZERO;
        end else if (fifo_pop) begin
            AddA <= float'(fifo_head[63:32]);
            AddB <= float'(fifo_head[31:0]);
        end
    end

    // Result register: load on capture or timeout, otherwise drain on acceptance
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            OutValid   <= 1'b0;
            OutResult  <= FP_ZERO;
            OutZero    <= 1'b0;
            OutInf     <= 1'b0;
            OutNan     <= 1'b0;
            OutTimeout <= 1'b0;
        end else if (do_capture) begin
            OutValid   <= 1'b1;
            OutResult  <= AddResult;
            OutZero    <= AddZero;
            OutInf     <= AddInf;
            OutNan     <= AddNan;
            OutTimeout <= 1'b0;
        end else if (do_timeout) begin
            OutValid   <= 1'b1;
            OutResult  <= FP_ZERO;
            OutZero    <= 1'b0;
            OutInf     <= 1'b0;
            OutNan     <= 1'b0;
            OutTimeout <= 1'b1;
        end else if (OutReady) begin
            OutValid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/fp_add_requester.md
# fp_add_requester

Request-side driver for the `FloatingPointAdder` Go/Ready handshake. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. It issues one addition at a time to the adder and holds the operands stable for the whole operation. It then captures `Result` and the `Zero`/`Inf`/`Nan` flags onto a valid/ready result stream, with a watchdog for adders that never respond.

## Interface
Parameters:
- `DEPTH`, 4: operand FIFO entries; must be a power of 2 and at least 2.
- `TIMEOUT`, 64: maximum cycles to wait for each adder handshake phase before a timeout result is forced.

Ports:
- `Clock`  in  1  — sole clock; all state updates on its rising edge.
- `ResetN`  in  1  — asynchronous, active-low reset.
- `InValid`  in  1  — operand pair valid.
- `InReady`  out  1  — FIFO not full.
- `InA`, `InB`  in  `float`  — operands.
- `OutValid`  out  1  — result valid.
- `OutReady`  in  1  — consumer accepts the result.
- `OutResult`  out  `float`  — captured sum.
- `OutZero`, `OutInf`, `OutNan`, `OutTimeout`  out  1 each  — captured flags; `OutTimeout` marks a forced result.
- `AddGo`  out  1  — start pulse to the adder.
- `AddA`, `AddB`  out  `float`  — adder operands.
- `AddReady`  in  1  — adder `Ready`.
- `AddResult`  in  `float`  — adder `Result`.
- `AddZero`, `AddInf`, `AddNan`  in  1 each  — adder flags.
- `Busy`  out  1  — FSM not in IDLE.
- `Count`  out  `$clog2(DEPTH)+1`  — current FIFO occupancy.

## Operation
- FIFO push: occurs when `InValid && InReady`. `InReady` is `!full`.
- FIFO pop: occurs only in IDLE. Simultaneous push and pop are legal; `Count` is then unchanged.
- FSM states are IDLE, ISSUE, ACK, WAIT.
- IDLE:
  - If the FIFO is not empty, pop the head into the operand registers `AddA`/`AddB`, clear the timer, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `AddGo` = 1 for exactly this cycle; then go to ACK.
- ACK: wait for `AddReady` = 0, which means the adder has dropped any stale Ready from the previous operation.
  - On `AddReady` = 0: clear the timer and go to WAIT.
  - A stale `AddReady` = 1 must never be taken as completion.
- WAIT: wait for `AddReady` = 1.
  - On `AddReady` = 1 with the output slot free (`!OutValid || OutReady`): capture `AddResult` and the three flags, set `OutTimeout` = 0, set `OutValid` = 1, and go to IDLE.
  - On `AddReady` = 1 with the output slot occupied: stay in WAIT. The adder holds Result and Ready stable until the next Go.
- Operand stability: `AddA`/`AddB` change only on a pop. They remain stable from ISSUE until the FSM returns to IDLE, because the adder re-samples its operands every cycle.
- Timer:
  - Increments each cycle in ACK, and in WAIT while `AddReady` = 0.
  - When it reaches `TIMEOUT` and the output slot is free: emit `OutResult` = 0, all three flags 0, `OutTimeout` = 1, and go to IDLE.
  - The timer saturates; it never wraps.
- Output register:
  - `OutValid` clears on `OutReady && OutValid` unless a new capture happens in the same cycle.
  - Fields hold while `OutValid && !OutReady`.
- Reset (`ResetN` = 0), asynchronous:
  - FSM returns to IDLE and the FIFO is emptied (`Count` = 0, `InReady` = 1).
  - All other outputs go to 0: `OutValid`, `AddGo`, `Busy`, `AddA`/`AddB`, `OutResult`, and every flag.
  - Reset mid-operation discards the in-flight operation; no result is emitted for it.

## Timing
- Push at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1, `AddGo` high during cycle N+1→N+2.
- `AddReady` sampled high in WAIT at edge M with the slot free: `OutValid` = 1 from edge M+1.
- Back-to-back operations: the FSM returns to IDLE the cycle after capture. Minimum issue-to-issue spacing is adder latency + 3 cycles.
- `Busy` = 1 in ISSUE, ACK and WAIT.
- `AddGo` is never high for two consecutive cycles.

## Structure
- `float` (sign/exp/frac) comes from `floatingpointpkg`; no local redefinition.
- Add to `floatingpointpkg`: a `req_state_t` enum for the FSM states and a `FP_ZERO` constant.
- Sub-module `fp_op_fifo`: synchronous FIFO, width 64 (A and B), depth `DEPTH`, async active-low reset. Ports: push, pop, data in, data out, full, empty, count.
- Top level contains the FSM, timer, operand registers and result register.

## Test plan
- Single op: push A = 0x3F800000, B = 0x40000000 into an adder model. Require exactly one `AddGo` pulse, `AddA`/`AddB` stable until capture, and `OutResult` = 0x40400000 with all flags 0.
- Fill: push 5 pairs back-to-back with `DEPTH` = 4 and a slow adder. Require `InReady` = 0 when `Count` = 4, and all results out in push order.
- Stale Ready: adder model leaves `AddReady` high for 2 cycles after Go. Require no capture until Ready has dropped and risen again.
- Backpressure: hold `OutReady` = 0 across two completions. Require the second operation to stall in WAIT with no result loss and no extra `AddGo`.
- Timeout: adder stub never raises `AddReady`. Require, `TIMEOUT` cycles after ACK exit, `OutValid` = 1, `OutTimeout` = 1, `OutResult` = 0, then service of the next queued pair.
- Reset mid-WAIT: drop `ResetN` asynchronously. Require immediate `OutValid` = 0, `Busy` = 0, `Count` = 0, and normal operation after release.
